// File: rtl/detect_sched.sv
// Round-robin scheduler time-sharing one serial 1-0-1 detector among N_REQ bit-stream requesters.
// Optional in-frame abort on request drop: define DETECT_SCHED_ABORT_EN.
module detect_sched #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] bit_in,
  output logic [N_REQ-1:0] gnt,
  output logic             shift,
  output logic             det_clr,
  output logic             det_in,
  input  logic             det_out,
  output logic             match,
  output logic             frame_done,
  output logic [2:0]       done_id,
  output logic [CNT_W-1:0] done_cnt,
  output logic             frame_abort
);

  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM} state_t;

  state_t               state;
  logic [IDX_W-1:0]     last;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     start;
  logic [IDX_W-1:0]     win;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     match_cnt;
  logic [2*N_REQ-1:0]   req2;
  logic [N_REQ-1:0]     rot;
  logic [N_REQ-1:0]     bit_sel;
  logic                 in_stream;
`ifdef DETECT_SCHED_ABORT_EN
  logic [N_REQ-1:0]     req_sel;
  logic                 owner_req;
`endif

  // Round-robin pick: rotate requests so last+1 sits at bit 0, lowest set bit wins
  always_comb begin
    start = (last == IDX_W'(N_REQ - 1)) ? '0 : last + 1'b1;
    req2  = {req, req};
    rot   = N_REQ'(req2 >> start);
    win   = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) win = IDX_W'((int'(start) + i) % int'(N_REQ));
    end
  end

  // Detector-side decode; det_clr also follows rst so the detector flushes with us
  always_comb begin
    in_stream = (state == STREAM);
    bit_sel   = bit_in >> owner;
`ifdef DETECT_SCHED_ABORT_EN
    req_sel   = req >> owner;
    owner_req = req_sel[0];
    det_in    = in_stream & owner_req & bit_sel[0];
`else
    det_in    = in_stream & bit_sel[0];
`endif
    shift     = in_stream;
    det_clr   = rst | (state == CLEAR);
    match     = det_out & in_stream;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= IDX_W'(N_REQ - 1);
      owner       <= '0;
      gnt         <= '0;
      bit_cnt     <= '0;
      match_cnt   <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      done_id     <= '0;
      done_cnt    <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= N_REQ'(1) << win;
            owner     <= win;
            last      <= win;
            bit_cnt   <= '0;
            match_cnt <= '0;
            state     <= CLEAR;
          end
        end
        CLEAR: state <= STREAM;
        STREAM: begin
`ifdef DETECT_SCHED_ABORT_EN
          if (!owner_req) begin
            gnt         <= '0;
            frame_abort <= 1'b1;
            done_id     <= owner;
            state       <= IDLE;
          end else
`endif
          begin
            bit_cnt <= bit_cnt + 1'b1;
            if (det_out) match_cnt <= match_cnt + 1'b1;
            // Final bit: report includes a hit landing on this very bit
            if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
              frame_done <= 1'b1;
              done_id    <= owner;
              done_cnt   <= match_cnt + CNT_W'(det_out);
              gnt        <= '0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detect_sched.sv
// Directed bench for detect_sched with a behavioural 1-0-1 detector and per-requester frame sources.
// Exercises the abort path when DETECT_SCHED_ABORT_EN is defined, run-to-completion otherwise.
module tb_detect_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] bit_in;
  logic [3:0] gnt;
  logic       shift, det_clr, det_in, det_out, match, frame_done, frame_abort;
  logic [2:0] done_id;
  logic [7:0] done_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] frame_bits [4];
  logic [3:0] ptr [4];
  logic [1:0] dst;

  detect_sched #(.N_REQ(4), .FRAME_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .gnt(gnt), .shift(shift),
    .det_clr(det_clr), .det_in(det_in), .det_out(det_out), .match(match),
    .frame_done(frame_done), .done_id(done_id), .done_cnt(done_cnt),
    .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  // Non-overlapping Mealy 1-0-1 detector: S0/S1/S2, returns to S0 after a hit
  assign det_out = (dst == 2'd2) && det_in;
  always @(posedge clk) begin
    if (det_clr) dst <= 2'd0;
    else case (dst)
      2'd0:    dst <= det_in ? 2'd1 : 2'd0;
      2'd1:    dst <= det_in ? 2'd1 : 2'd2;
      default: dst <= 2'd0;
    endcase
  end

  // Requester bit sources advance on gnt & shift
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!gnt[i]) ptr[i] <= 4'd0;
      else if (shift) ptr[i] <= ptr[i] + 4'd1;
    end
  end

  always_comb begin
    bit_in = '0;
    for (int i = 0; i < 4; i++) bit_in[i] = frame_bits[i][ptr[i][2:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) frame_bits[i] = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000 || frame_done !== 1'b0 || frame_abort !== 1'b0 ||
        done_id !== 3'd0 || done_cnt !== 8'd0 || det_clr !== 1'b1 || shift !== 1'b0 ||
        det_in !== 1'b0 || match !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals: gnt=%b fd=%b fa=%b id=%0d cnt=%0d clr=%b shift=%b din=%b m=%b want 0000/0/0/0/0/1/0/0/0",
               gnt, frame_done, frame_abort, done_id, done_cnt, det_clr, shift, det_in, match);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (det_clr !== 1'b0) begin
      failures++;
      $display("FAIL idle_clr: det_clr=%b want 0", det_clr);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_m;
    exp_m = 8'h04;
    do_reset();
    frame_bits[0] = 8'h15;  // 1,0,1,0,1,0,0,0 bit 0 first
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || det_clr !== 1'b1 || shift !== 1'b0) begin
      failures++;
      $display("FAIL single_clear: gnt=%b clr=%b shift=%b want 0001/1/0", gnt, det_clr, shift);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (match !== exp_m[k] || shift !== 1'b1 || det_in !== frame_bits[0][k]) begin
        failures++;
        $display("FAIL single_step%0d: match=%b shift=%b din=%b want %b/1/%b",
                 k, match, shift, det_in, exp_m[k], frame_bits[0][k]);
      end
      tick();
    end
    checks++;
    if (frame_done !== 1'b1 || done_id !== 3'd0 || done_cnt !== 8'd1 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL single_done: fd=%b id=%0d cnt=%0d gnt=%b want 1/0/1/0000",
               frame_done, done_id, done_cnt, gnt);
    end
    req = 4'b0000;
    tick();
    tick();
    checks++;
    if (frame_done !== 1'b0 || done_id !== 3'd0 || done_cnt !== 8'd1 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL single_hold: fd=%b id=%0d cnt=%0d gnt=%b want 0/0/1/0000",
               frame_done, done_id, done_cnt, gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    req = 4'b1111;
    tick();
    for (int f = 0; f < 5; f++) begin
      eg = 4'b0001 << (f % 4);
      checks++;
      if (gnt !== eg) begin
        failures++;
        $display("FAIL rr_grant%0d: gnt=%b want %b", f, gnt, eg);
      end
      for (int c = 0; c < 9; c++) tick();
      checks++;
      if (frame_done !== 1'b1 || done_id !== 3'(f % 4) || done_cnt !== 8'd0) begin
        failures++;
        $display("FAIL rr_done%0d: fd=%b id=%0d cnt=%0d want 1/%0d/0",
                 f, frame_done, done_id, done_cnt, f % 4);
      end
      if (f == 4) req = 4'b0000;
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    frame_bits[1] = 8'h40;  // ...,1,0: ends in S2
    frame_bits[2] = 8'h01;  // first bit 1
    req = 4'b0110;
    tick();
    checks++;
    if (gnt !== 4'b0010 || det_clr !== 1'b1) begin
      failures++;
      $display("FAIL flush_clear1: gnt=%b clr=%b want 0010/1", gnt, det_clr);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (det_clr !== 1'b0 || match !== 1'b0) begin
        failures++;
        $display("FAIL flush_step%0d: clr=%b match=%b want 0/0", k, det_clr, match);
      end
      tick();
    end
    checks++;
    if (frame_done !== 1'b1 || done_id !== 3'd1 || det_clr !== 1'b0) begin
      failures++;
      $display("FAIL flush_done1: fd=%b id=%0d clr=%b want 1/1/0", frame_done, done_id, det_clr);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || det_clr !== 1'b1) begin
      failures++;
      $display("FAIL flush_clear2: gnt=%b clr=%b want 0100/1", gnt, det_clr);
    end
    tick();
    checks++;
    if (det_in !== 1'b1 || match !== 1'b0 || det_clr !== 1'b0) begin
      failures++;
      $display("FAIL flush_first: din=%b match=%b clr=%b want 1/0/0", det_in, match, det_clr);
    end
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (frame_done !== 1'b1 || done_id !== 3'd2 || done_cnt !== 8'd0) begin
      failures++;
      $display("FAIL flush_done2: fd=%b id=%0d cnt=%0d want 1/2/0", frame_done, done_id, done_cnt);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    frame_bits[2] = 8'hFF;
    req = 4'b0100;
    tick();
    tick();
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (gnt !== 4'b0100 || shift !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: gnt=%b shift=%b want 0100/1", gnt, shift);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0000 || frame_done !== 1'b0 || shift !== 1'b0 || det_clr !== 1'b1) begin
      failures++;
      $display("FAIL midrst_rst: gnt=%b fd=%b shift=%b clr=%b want 0000/0/0/1",
               gnt, frame_done, shift, det_clr);
    end
    rst = 1'b0;
    req = 4'b1111;
    #1;
    checks++;
    if (frame_done !== 1'b0 || done_cnt !== 8'd0 || done_id !== 3'd0) begin
      failures++;
      $display("FAIL midrst_nodone: fd=%b cnt=%0d id=%0d want 0/0/0", frame_done, done_cnt, done_id);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_regrant: gnt=%b want 0001", gnt);
    end
    for (int c = 0; c < 9; c++) tick();
    checks++;
    if (frame_done !== 1'b1 || done_id !== 3'd0) begin
      failures++;
      $display("FAIL midrst_done: fd=%b id=%0d want 1/0", frame_done, done_id);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_alternating();
    logic [7:0] exp_m;
    exp_m = 8'h44;
    do_reset();
    frame_bits[0] = 8'h55;  // 1,0,1,0,1,0,1,0
    req = 4'b0001;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (match !== exp_m[k]) begin
        failures++;
        $display("FAIL alt_step%0d: match=%b want %b", k, match, exp_m[k]);
      end
      tick();
    end
    checks++;
    if (frame_done !== 1'b1 || done_cnt !== 8'd2 || done_id !== 3'd0) begin
      failures++;
      $display("FAIL alt_done: fd=%b cnt=%0d id=%0d want 1/2/0", frame_done, done_cnt, done_id);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_req_drop();
    do_reset();
    frame_bits[0] = 8'hFF;
    req = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL drop_grant: gnt=%b want 0001", gnt);
    end
    tick();
    for (int c = 0; c < 3; c++) tick();
    req = 4'b0010;
    #1;
`ifdef DETECT_SCHED_ABORT_EN
    checks++;
    if (det_in !== 1'b0 || match !== 1'b0) begin
      failures++;
      $display("FAIL abort_bit: din=%b match=%b want 0/0", det_in, match);
    end
    tick();
    checks++;
    if (frame_abort !== 1'b1 || frame_done !== 1'b0 || done_id !== 3'd0 ||
        gnt !== 4'b0000 || done_cnt !== 8'd0) begin
      failures++;
      $display("FAIL abort_pulse: fa=%b fd=%b id=%0d gnt=%b cnt=%0d want 1/0/0/0000/0",
               frame_abort, frame_done, done_id, gnt, done_cnt);
    end
`else
    checks++;
    if (det_in !== 1'b1 || shift !== 1'b1) begin
      failures++;
      $display("FAIL noabort_bit: din=%b shift=%b want 1/1", det_in, shift);
    end
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (frame_done !== 1'b1 || frame_abort !== 1'b0 || done_id !== 3'd0 || done_cnt !== 8'd0) begin
      failures++;
      $display("FAIL noabort_done: fd=%b fa=%b id=%0d cnt=%0d want 1/0/0/0",
               frame_done, frame_abort, done_id, done_cnt);
    end
`endif
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL drop_next: gnt=%b want 0010", gnt);
    end
    req = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) frame_bits[i] = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_mid_reset();
    test_alternating();
    test_req_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
